// File: rtl/aes_result_capture_if.sv
// Wishbone slave bus used to read back AES results and status.
interface aes_result_capture_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/aes_result_capture.sv
// Times an AES run from the start edge, latches the ciphertext and
// exposes result words, status and a done interrupt over Wishbone.
module aes_result_capture #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
    parameter logic [31:0] CIPHERTEXT_ADDR = BASE_ADDRESS + 32'd48,
    parameter logic [31:0] STATUS_ADDR     = BASE_ADDRESS + 32'd68,
    parameter int unsigned LATENCY         = 15
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    aes_result_capture_if.slave wbs,
    input  logic                start_i,
    input  logic [127:0]        ciphertext_i,
    output logic                done_irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    state_t       state;
    logic [7:0]   cnt;
    logic [127:0] result;
    logic         done;
    logic         overrun;
    logic [7:0]   count;
    logic         start_q;
    logic         ack;
    logic [31:0]  dat;

    logic [31:0]  ct_off;
    logic         hit_ct;
    logic         hit_st;
    logic         req;
    logic         clr_done;
    logic         clr_ovr;
    logic         start_ev;
    logic [31:0]  status;
    logic [31:0]  rdata;
    logic         unused_bits;

    assign unused_bits = ^{wbs.wbs_dat_i[31:3], wbs.wbs_dat_i[0]};

    // Result words decode by offset so any word-aligned base works.
    assign ct_off   = wbs.wbs_adr_i - CIPHERTEXT_ADDR;
    assign hit_ct   = (ct_off < 32'd16) && (ct_off[1:0] == 2'b00);
    assign hit_st   = (wbs.wbs_adr_i == STATUS_ADDR);
    assign req      = wbs.wbs_cyc_i && wbs.wbs_stb_i
                      && (hit_ct || hit_st) && !ack;
    assign clr_done = req && wbs.wbs_we_i && hit_st && wbs.wbs_dat_i[1];
    assign clr_ovr  = req && wbs.wbs_we_i && hit_st && wbs.wbs_dat_i[2];
    assign start_ev = start_i && !start_q;

    assign status = {16'h0, count, 5'h0, overrun, done, state == S_WAIT};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_st:  rdata = status;
            hit_ct:  rdata = result[32*ct_off[3:2] +: 32];
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            result  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
            start_q <= 1'b0;
            ack     <= 1'b0;
            dat     <= '0;
        end else begin
            start_q <= start_i;
            ack     <= req;
            dat     <= (req && !wbs.wbs_we_i) ? rdata : '0;
            // A same-cycle overrun below overrides this clear.
            if (clr_ovr) overrun <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_ev) begin
                        state <= S_WAIT;
                        cnt   <= LOAD;
                    end
                end
                S_WAIT: begin
                    if (start_ev) begin
                        cnt     <= LOAD;
                        overrun <= 1'b1;
                    end else if (cnt == 8'd0) begin
                        result <= ciphertext_i;
                        state  <= S_DONE;
                        done   <= 1'b1;
                        count  <= count + 8'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (start_ev) begin
                        state <= S_WAIT;
                        cnt   <= LOAD;
                        done  <= 1'b0;
                    end else if (clr_done) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wbs.wbs_ack_o = ack;
    assign wbs.wbs_dat_o = dat;
    assign done_irq_o    = done;

endmodule

// File: tb/tb_aes_result_capture.sv
// Directed and randomized checks of aes_result_capture against a
// time-stamped reference model of the capture rules.
module tb_aes_result_capture;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CT   = BASE + 32'd48;
    localparam logic [31:0] ST   = BASE + 32'd68;
    localparam int unsigned LAT  = 15;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] ct;
    logic         irq;

    aes_result_capture_if bus ();

    aes_result_capture #(
        .BASE_ADDRESS(BASE),
        .CIPHERTEXT_ADDR(CT),
        .STATUS_ADDR(ST),
        .LATENCY(LAT)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs(bus.slave),
        .start_i(start),
        .ciphertext_i(ct),
        .done_irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is pending until an absolute deadline.
    bit           m_busy, m_done, m_ovr, m_prev, m_ack;
    longint       m_cyc, m_deadline;
    logic [127:0] m_res;
    logic [7:0]   m_cnt;
    logic [31:0]  m_dat;

    function automatic logic [31:0] m_status();
        return {16'h0, m_cnt, 5'h0, m_ovr, m_done, m_busy};
    endfunction

    task automatic mreset();
        m_busy = 0; m_done = 0; m_ovr = 0; m_prev = 0; m_ack = 0;
        m_deadline = 0; m_res = '0; m_cnt = '0; m_dat = '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        hit;
        logic [31:0] rv;
        bit          sev, cap, ovset, req;
        hit = 0; rv = '0; cap = 0; ovset = 0;
        if (bus.wbs_adr_i == ST) begin
            hit = 1; rv = m_status();
        end
        for (int k = 0; k < 4; k++)
            if (bus.wbs_adr_i == CT + 32'(4 * k)) begin
                hit = 1; rv = m_res[32*k +: 32];
            end
        req = bus.wbs_cyc_i && bus.wbs_stb_i && hit && !m_ack;
        sev = start && !m_prev;
        if (sev) begin
            if (m_busy) begin m_ovr = 1; ovset = 1; end
            m_busy = 1; m_done = 0; m_deadline = m_cyc + LAT;
        end else if (m_busy && m_cyc == m_deadline) begin
            m_res = ct; m_busy = 0; m_done = 1; m_cnt++; cap = 1;
        end
        if (req && bus.wbs_we_i && bus.wbs_adr_i == ST) begin
            if (bus.wbs_dat_i[1] && !cap) m_done = 0;
            if (bus.wbs_dat_i[2] && !ovset) m_ovr = 0;
        end
        m_ack  = req;
        m_dat  = (req && !bus.wbs_we_i) ? rv : '0;
        m_prev = start;
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
        chk("irq", irq, m_done);
        chk("ack", bus.wbs_ack_o, m_ack);
        chk("dat", bus.wbs_dat_o, m_dat);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
        bus.wbs_adr_i = a;
        step();
        v = bus.wbs_dat_o;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = a; bus.wbs_dat_i = d;
        step();
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        step();
    endtask

    task automatic run_op();
        start = 1; step();
        start = 0; steps(LAT);
    endtask

    logic [31:0] v;
    logic [3:0]  pat;
    logic [31:0] addrs [6];

    initial begin
        rst = 1; start = 0; ct = '0; m_cyc = 0;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ack", bus.wbs_ack_o, 1'b0);
        rst = 0;
        rd(ST, v);
        chk("rst_status", v, 32'h0);

        // Basic capture and word order.
        ct = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        start = 1; step();
        steps(3);
        start = 0; steps(11);
        chk("irq_before", irq, 1'b0);
        step();
        chk("irq_at_16", irq, 1'b1);
        ct = '0;
        rd(CT, v);        chk("word0", v, 32'hCCDDEEFF);
        rd(CT + 4, v);    chk("word1", v, 32'h8899AABB);
        rd(CT + 8, v);    chk("word2", v, 32'h44556677);
        rd(CT + 12, v);   chk("word3", v, 32'h00112233);
        rd(ST, v);        chk("status1", v, 32'h0000_0102);
        wr(CT, 32'hFFFF_FFFF);
        rd(CT, v);        chk("ct_write_ignored", v, 32'hCCDDEEFF);

        // Overrun from a second edge five cycles in.
        start = 1; step();
        start = 0; steps(4);
        start = 1; step();
        start = 0; steps(14);
        chk("ovr_irq_early", irq, 1'b0);
        step();
        chk("ovr_irq", irq, 1'b1);
        rd(ST, v);        chk("status_ovr", v, 32'h0000_0206);
        wr(ST, 32'h4);
        rd(ST, v);        chk("status_ovr_clr", v, 32'h0000_0202);

        // Done-clear racing a capture.
        start = 1; step();
        start = 0; steps(LAT - 1);
        wr(ST, 32'h2);
        chk("race_irq", irq, 1'b1);
        rd(ST, v);        chk("race_status", v, 32'h0000_0302);
        wr(ST, 32'h2);
        chk("clr_irq", irq, 1'b0);
        rd(ST, v);        chk("clr_status", v, 32'h0000_0300);

        // Randomized traffic against the model.
        addrs[0] = CT; addrs[1] = CT + 4; addrs[2] = CT + 8;
        addrs[3] = CT + 12; addrs[4] = ST; addrs[5] = BASE + 100;
        for (int i = 0; i < 800; i++) begin
            ct = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 11) == 0) start = ~start;
            bus.wbs_cyc_i = ($urandom_range(0, 9) < 4);
            bus.wbs_stb_i = bus.wbs_cyc_i && ($urandom_range(0, 7) != 0);
            bus.wbs_we_i  = ($urandom_range(0, 3) == 0);
            bus.wbs_adr_i = addrs[$urandom_range(0, 5)];
            bus.wbs_dat_i = $urandom;
            step();
        end
        start = 0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        bus.wbs_we_i = 0;
        step();

        // Completion count wraps after 256 runs.
        @(negedge clk); rst = 1; @(negedge clk); rst = 0; mreset();
        for (int i = 0; i < 256; i++) run_op();
        rd(ST, v);        chk("count_256", v[15:8], 8'd0);
        run_op();
        rd(ST, v);        chk("count_257", v[15:8], 8'd1);

        // Reset mid-WAIT during an acked read.
        start = 1; step();
        start = 0; steps(5);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = ST;
        step();
        chk("pre_rst_ack", bus.wbs_ack_o, 1'b1);
        #2 rst = 1;
        #1;
        chk("async_ack", bus.wbs_ack_o, 1'b0);
        chk("async_dat", bus.wbs_dat_o, 32'h0);
        chk("async_irq", irq, 1'b0);
        @(negedge clk);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        rst = 0; mreset();
        steps(20);
        chk("no_capture", irq, 1'b0);
        rd(ST, v);        chk("post_rst_status", v, 32'h0);

        // Start held high across reset release is an edge.
        rst = 1; start = 1;
        @(negedge clk);
        rst = 0; mreset();
        step();
        rd(ST, v);        chk("start_after_rst", v, 32'h1);
        start = 0;

        // Unmapped and held-mapped handshakes.
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
        bus.wbs_adr_i = BASE + 100;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat[i] = bus.wbs_ack_o;
        end
        chk("unmapped_ack", pat, 4'b0000);
        bus.wbs_adr_i = CT;
        pat[3] = bus.wbs_ack_o;
        step(); pat[2] = bus.wbs_ack_o;
        step(); pat[1] = bus.wbs_ack_o;
        step(); pat[0] = bus.wbs_ack_o;
        chk("held_pattern", pat, 4'b0101);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
